// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - Flappy Bird game FSM with pipe spawn/scroll/retire, gap LFSR and score
module pipe_scheduler #(
    parameter int unsigned N_PIPES      = 3,
    parameter int unsigned SPAWN_X      = 639,
    parameter int unsigned SPAWN_FRAMES = 200,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned GAP_MIN      = 60,
    parameter int unsigned BIRD_X       = 300
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    collide,
    output logic [10*N_PIPES-1:0]   pipe_x,
    output logic [10*N_PIPES-1:0]   pipe_gap_y,
    output logic [N_PIPES-1:0]      pipe_active,
    output logic [7:0]              score,
    output logic [1:0]              game_state
);

    localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_FRAMES - 1);
    localparam logic [9:0] SPAWN_X_V = 10'(SPAWN_X);
    localparam logic [9:0] STEP_V    = 10'(SCROLL_STEP);
    localparam logic [9:0] GAP_MIN_V = 10'(GAP_MIN);
    localparam logic [9:0] BIRD_X_V  = 10'(BIRD_X);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               start_q;
    logic               start_rise;
    logic [7:0]         lfsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [9:0]         x_q   [N_PIPES];
    logic [9:0]         x_d   [N_PIPES];
    logic [9:0]         gap_q [N_PIPES];
    logic [9:0]         gap_d [N_PIPES];
    logic [N_PIPES-1:0] act_q;
    logic [N_PIPES-1:0] act_d;
    logic [7:0]         score_q;
    logic [7:0]         score_d;
    logic [2:0]         pass_cnt;
    logic [8:0]         score_sum;
    logic               spawn_found;

    assign start_rise = start & ~start_q;

    // Game state register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Game state transitions; the unused encoding falls back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_rise) state_d = S_RUN;
            S_RUN:   if (collide)    state_d = S_OVER;
            S_OVER:  if (start_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-frame pipe field update, computed entirely from pre-edge values
    always_comb begin
        x_d         = x_q;
        gap_d       = gap_q;
        act_d       = act_q;
        score_d     = score_q;
        cnt_d       = cnt_q;
        pass_cnt    = 3'd0;
        score_sum   = 9'd0;
        spawn_found = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    act_d   = '0;
                    score_d = 8'd0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // A collision freezes the field exactly as it was
                if (!collide) begin
                    for (int i = 0; i < int'(N_PIPES); i++) begin
                        if (act_q[i]) begin
                            if (x_q[i] < STEP_V) begin
                                act_d[i] = 1'b0;
                            end else begin
                                x_d[i] = x_q[i] - STEP_V;
                                if ((x_q[i] > BIRD_X_V) && ((x_q[i] - STEP_V) <= BIRD_X_V)) begin
                                    pass_cnt = pass_cnt + 3'd1;
                                end
                            end
                        end
                    end
                    score_sum = {1'b0, score_q} + {6'd0, pass_cnt};
                    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                    if (cnt_q == '0) begin
                        // Freedom is judged pre-edge, so a slot retiring now is not reused yet
                        for (int i = 0; i < int'(N_PIPES); i++) begin
                            if (!act_q[i] && !spawn_found) begin
                                spawn_found = 1'b1;
                                act_d[i]    = 1'b1;
                                x_d[i]      = SPAWN_X_V;
                                gap_d[i]    = GAP_MIN_V + {2'b00, lfsr_q};
                            end
                        end
                        if (spawn_found) begin
                            cnt_d = CNT_RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Pipe field, score, spawn timer, start edge detector and gap LFSR registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(N_PIPES); i++) begin
                x_q[i]   <= SPAWN_X_V;
                gap_q[i] <= GAP_MIN_V;
            end
            act_q   <= '0;
            score_q <= 8'd0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            lfsr_q  <= 8'hA5;
        end else begin
            x_q     <= x_d;
            gap_q   <= gap_d;
            act_q   <= act_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            start_q <= start;
            // Taps 8,6,5,4; a stuck-at-zero state is forced back to the seed
            if (lfsr_q == 8'h00) begin
                lfsr_q <= 8'hA5;
            end else begin
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < int'(N_PIPES); g++) begin : g_pack
            assign pipe_x[10*g +: 10]     = x_q[g];
            assign pipe_gap_y[10*g +: 10] = gap_q[g];
        end
    endgenerate

    assign pipe_active = act_q;
    assign score       = score_q;
    assign game_state  = state_q;

endmodule
